// File: rtl/gups_pkg.sv
// Shared types and constants for the GUPS memory controller.
package gups_pkg;

    localparam int unsigned DataW        = 64;
    localparam int unsigned AddrWDefault = 10;
    localparam int unsigned RdLatDefault = 2;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StRdWait,
        StRdResp,
        StWrWait,
        StWrAck,
        StRelease
    } gups_state_e;

endpackage

// File: rtl/gups_ram.sv
// Single-port RAM with synchronous write and a one-cycle registered read.
module gups_ram #(
    parameter int unsigned AddrW = 10,
    parameter int unsigned DataW = 64
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [DataW-1:0] wdata_i,
    output logic [DataW-1:0] rdata_o
);

    logic [DataW-1:0] mem_q [1 << AddrW];
    logic [DataW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/gups_mem_ctrl.sv
// GUPS read-modify-write memory controller: initialises RAM to its index, then serves
// read/write phases from the generator and counts completed updates.
module gups_mem_ctrl
    import gups_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrWDefault,
    parameter int unsigned RD_LAT = RdLatDefault
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DataW-1:0] address,
    input  logic [DataW-1:0] data_in,
    input  logic             req,
    input  logic             write,
    output logic [DataW-1:0] dout,
    output logic             ready,
    output logic             busy,
    output logic [DataW-1:0] update_count,
    output logic             addr_err,
    output logic             proto_err
);

    gups_state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] init_idx_q;
    logic [3:0]        wait_cnt_q;
    logic [DataW-1:0]  dout_q;
    logic [DataW-1:0]  count_q;
    logic              addr_err_q;
    logic              proto_err_q;

    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DataW-1:0]  ram_wdata;
    logic [DataW-1:0]  ram_rdata;

    logic rd_accept;
    logic wr_fire;
    logic proto_hit;
    logic init_done;
    logic wait_done;

    assign rd_accept = (state_q == StIdle) && req && !write;
    assign proto_hit = (state_q == StIdle) && req && write;
    assign wr_fire   = (state_q == StWrWait) && req && write;
    assign init_done = (init_idx_q == {ADDR_W{1'b1}});
    assign wait_done = (wait_cnt_q == 4'(RD_LAT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:    if (init_done) state_d = StIdle;
            StIdle:    if (rd_accept) state_d = StRdWait;
            StRdWait:  if (wait_done) state_d = StRdResp;
            StRdResp:  state_d = StWrWait;
            StWrWait: begin
                if (!req) begin
                    state_d = StIdle;
                end else if (write) begin
                    state_d = StWrAck;
                end
            end
            StWrAck:   state_d = StRelease;
            StRelease: if (!req) state_d = StIdle;
            default:   state_d = StInit;
        endcase
    end

    // RAM port: INIT owns it while busy; IDLE presents the live address so the read
    // issues on the accept edge; otherwise the latched address is used.
    always_comb begin
        ready     = (state_q == StRdResp) || (state_q == StWrAck);
        busy      = (state_q == StInit);
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = data_in;
        if (state_q == StInit) begin
            ram_we    = !reset;
            ram_addr  = init_idx_q;
            ram_wdata = {{(DataW - ADDR_W){1'b0}}, init_idx_q};
        end else if (state_q == StIdle) begin
            ram_re   = rd_accept && !reset;
            ram_addr = address[ADDR_W-1:0];
        end else if (wr_fire) begin
            ram_we = !reset;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            init_idx_q  <= '0;
            wait_cnt_q  <= '0;
            dout_q      <= '0;
            count_q     <= '0;
            addr_err_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            if (state_q == StInit) begin
                init_idx_q <= init_idx_q + ADDR_W'(1);
            end
            if (rd_accept) begin
                addr_q     <= address[ADDR_W-1:0];
                wait_cnt_q <= '0;
                if (|address[DataW-1:ADDR_W]) begin
                    addr_err_q <= 1'b1;
                end
            end
            if (state_q == StRdWait) begin
                wait_cnt_q <= wait_cnt_q + 4'd1;
                // RAM holds its registered output until the next read, so sampling it
                // at the end of the wait supplies the extra RD_LAT-1 cycles of delay.
                if (wait_done) begin
                    dout_q <= ram_rdata;
                end
            end
            if (state_q == StWrAck) begin
                count_q <= count_q + 64'd1;
            end
            if (proto_hit) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    gups_ram #(
        .AddrW (ADDR_W),
        .DataW (DataW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign dout         = dout_q;
    assign update_count = count_q;
    assign addr_err     = addr_err_q;
    assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_gups_mem_ctrl.sv
// Directed scoreboard bench for gups_mem_ctrl (ADDR_W=10, RD_LAT=2).
module tb_gups_mem_ctrl;

    localparam int unsigned AW    = 10;
    localparam int unsigned RL    = 2;
    localparam int unsigned DEPTH = 1 << AW;

    logic        clk;
    logic        reset;
    logic [63:0] address;
    logic [63:0] data_in;
    logic        req;
    logic        write;
    logic [63:0] dout;
    logic        ready;
    logic        busy;
    logic [63:0] update_count;
    logic        addr_err;
    logic        proto_err;

    int          n_checks;
    int          n_fail;
    logic [63:0] exp_q [$];
    logic [63:0] model [DEPTH];
    logic [63:0] exp_count;
    logic [63:0] last_read;
    int unsigned cur_addr;
    bit          ready_seen;
    int          busy_cycles;

    gups_mem_ctrl #(
        .ADDR_W (AW),
        .RD_LAT (RL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .data_in      (data_in),
        .req          (req),
        .write        (write),
        .dout         (dout),
        .ready        (ready),
        .busy         (busy),
        .update_count (update_count),
        .addr_err     (addr_err),
        .proto_err    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 64'(i);
    endtask

    // Called at a negedge right after a reset edge; counts negedges with busy high.
    task automatic wait_init(output int cnt);
        cnt = 0;
        ready_seen = 1'b0;
        while (busy === 1'b1 && cnt < 3000) begin
            if (ready === 1'b1) ready_seen = 1'b1;
            if (cnt == 500) begin
                req   = 1'b0;
                write = 1'b0;
            end
            cnt++;
            @(negedge clk);
        end
        if (ready === 1'b1) ready_seen = 1'b1;
        req   = 1'b0;
        write = 1'b0;
    endtask

    // Issue a read from IDLE and wait for the response; ends at the RD_RESP negedge.
    task automatic read_phase(input logic [63:0] addr, input string tag);
        int n;
        cur_addr = int'(addr[AW-1:0]);
        exp_q.push_back(model[cur_addr]);
        address = addr;
        req     = 1'b1;
        write   = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready !== 1'b1 && n < 50);
        check({tag, "_latency"}, 64'(n), 64'(RL + 1));
        if (exp_q.size() > 0) begin
            last_read = exp_q.pop_front();
            check({tag, "_dout"}, dout, last_read);
        end
    endtask

    // From RD_RESP: write phase, ack, release; ends with the FSM in IDLE.
    task automatic write_phase(input logic [63:0] data, input string tag);
        int n;
        int extra;
        write   = 1'b1;
        data_in = data;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready !== 1'b1 && n < 50);
        check({tag, "_ack_delay"}, 64'(n), 64'd2);
        model[cur_addr] = data;
        exp_count++;
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ready === 1'b1) extra++;
        end
        check({tag, "_extra_ready"}, 64'(extra), 64'd0);
        check({tag, "_count"}, update_count, exp_count);
        check({tag, "_dout_hold"}, dout, last_read);
        req   = 1'b0;
        write = 1'b0;
        @(negedge clk);
    endtask

    // From RD_RESP: drop req so WR_WAIT aborts; ends with the FSM in IDLE.
    task automatic abort_phase(input string tag);
        int pulses;
        req    = 1'b0;
        write  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ready === 1'b1) pulses++;
        end
        check({tag, "_abort_ready"}, 64'(pulses), 64'd0);
        check({tag, "_abort_count"}, update_count, exp_count);
    endtask

    initial begin
        int pulses;
        logic [63:0] a;
        n_checks  = 0;
        n_fail    = 0;
        exp_count = 64'd0;
        last_read = 64'd0;
        reset     = 1'b1;
        req       = 1'b0;
        write     = 1'b0;
        address   = 64'd0;
        data_in   = 64'd0;

        // Reset state, then INIT with a request held high that must be ignored.
        @(negedge clk);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_dout", dout, 64'd0);
        check("rst_count", update_count, 64'd0);
        check("rst_addr_err", 64'(addr_err), 64'd0);
        check("rst_proto_err", 64'(proto_err), 64'd0);
        reset   = 1'b0;
        req     = 1'b1;
        write   = 1'b1;
        address = 64'd1;
        data_in = 64'hBAD;
        wait_init(busy_cycles);
        check("init_busy_cycles", 64'(busy_cycles), 64'(DEPTH));
        check("init_ready_seen", 64'(ready_seen), 64'd0);
        check("init_proto_err", 64'(proto_err), 64'd0);
        check("init_addr_err", 64'(addr_err), 64'd0);
        check("init_count", update_count, 64'd0);
        model_init();

        // Out-of-range read is truncated and flags addr_err.
        read_phase(64'hFFFF_0000_0000_0405, "oob");
        check("oob_addr_err", 64'(addr_err), 64'd1);
        abort_phase("oob");

        // Read-modify-write of address 5, then reread.
        read_phase(64'd5, "rd5");
        write_phase(64'd6, "wr5");
        read_phase(64'd5, "rerd5");
        abort_phase("rerd5");
        check("addr_err_sticky", 64'(addr_err), 64'd1);
        check("proto_err_clean", 64'(proto_err), 64'd0);

        // Write request in IDLE: protocol error, no access, no ready.
        address = 64'd3;
        data_in = 64'hDEAD;
        req     = 1'b1;
        write   = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ready === 1'b1) pulses++;
        end
        req   = 1'b0;
        write = 1'b0;
        @(negedge clk);
        check("proto_err_set", 64'(proto_err), 64'd1);
        check("proto_ready", 64'(pulses), 64'd0);
        read_phase(64'd3, "rd3");
        abort_phase("rd3");

        // Abort in WR_WAIT leaves RAM and count alone.
        read_phase(64'd7, "rd7");
        abort_phase("rd7");
        read_phase(64'd7, "rerd7");
        abort_phase("rerd7");

        // Random read-modify-writes, then read back the last one.
        for (int k = 0; k < 4; k++) begin
            a = 64'($urandom_range(0, DEPTH - 1));
            read_phase(a, "rnd_rd");
            write_phase({$urandom, $urandom}, "rnd_wr");
        end
        read_phase(a, "rnd_back");
        abort_phase("rnd_back");
        check("proto_err_sticky", 64'(proto_err), 64'd1);

        // Write 9, then reset in RD_WAIT of a read of 9; INIT restores RAM[9]=9.
        read_phase(64'd9, "rd9");
        write_phase(64'h0999, "wr9");
        address = 64'd9;
        req     = 1'b1;
        write   = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        req   = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", 64'(ready), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd1);
        check("mid_rst_count", update_count, 64'd0);
        check("mid_rst_dout", dout, 64'd0);
        check("mid_rst_addr_err", 64'(addr_err), 64'd0);
        check("mid_rst_proto_err", 64'(proto_err), 64'd0);
        reset     = 1'b0;
        exp_count = 64'd0;
        wait_init(busy_cycles);
        check("reinit_busy_cycles", 64'(busy_cycles), 64'(DEPTH));
        check("reinit_ready_seen", 64'(ready_seen), 64'd0);
        model_init();
        read_phase(64'd9, "post_rst_rd9");
        abort_phase("post_rst_rd9");
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
